// File: rtl/chan_packet_accum_ctrl.sv
// Channel packet integrator: sums N signed samples after a software start and
// a frame sync, then strobes the total out once; optional back-to-back runs.
module chan_packet_accum_ctrl #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned ACC_W = 32
) (
   input  logic                    user_clk,
   input  logic                    user_rst,
   input  logic [31:0]             ctrl_reg,
   input  logic signed [IN_W-1:0]  din,
   input  logic                    din_valid,
   input  logic                    sync_in,
   output logic signed [ACC_W-1:0] acc_out,
   output logic                    acc_valid,
   output logic                    busy,
   output logic [15:0]             dump_cnt,
   output logic                    err_zero_len
);

   localparam int unsigned LEN_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      ACCUM = 2'd2
   } state_t;

   state_t                  state_q, state_n;
   logic                    start_q;
   logic [LEN_W-1:0]        len_q, len_n;
   logic [LEN_W-1:0]        cnt_q, cnt_n;
   logic signed [ACC_W-1:0] acc_q, acc_n;
   logic signed [ACC_W-1:0] acc_out_n;
   logic                    acc_valid_n;
   logic                    busy_n;
   logic [15:0]             dump_cnt_n;
   logic                    err_zero_len_n;

   logic                    start_edge_c;
   logic [LEN_W-1:0]        n_field_c;
   logic signed [ACC_W-1:0] din_ext_c;
   logic signed [ACC_W-1:0] sum_c;
   logic [LEN_W-1:0]        cnt_inc_c;
   logic                    done_c;
   logic signed [ACC_W-1:0] done_val_c;
   logic                    unused_ctrl;

   assign unused_ctrl  = ^ctrl_reg[15:2];
   assign start_edge_c = ctrl_reg[0] & ~start_q;
   assign n_field_c    = ctrl_reg[31:16];
   assign din_ext_c    = ACC_W'($signed(din));
   assign sum_c        = acc_q + din_ext_c;
   assign cnt_inc_c    = cnt_q + LEN_W'(1);

   // Next-state and next-output logic
   always_comb begin
      state_n        = state_q;
      len_n          = len_q;
      cnt_n          = cnt_q;
      acc_n          = acc_q;
      acc_out_n      = acc_out;
      acc_valid_n    = 1'b0;
      dump_cnt_n     = dump_cnt;
      err_zero_len_n = err_zero_len;
      done_c         = 1'b0;
      done_val_c     = '0;

      case (state_q)
         IDLE: begin
            if (start_edge_c) begin
               if (n_field_c != '0) begin
                  len_n   = n_field_c;
                  acc_n   = '0;
                  cnt_n   = '0;
                  state_n = ARM;
               end else begin
                  err_zero_len_n = 1'b1;
               end
            end
         end
         ARM: begin
            if (din_valid && sync_in) begin
               if (len_q == LEN_W'(1)) begin
                  done_c     = 1'b1;
                  done_val_c = din_ext_c;
               end else begin
                  acc_n   = din_ext_c;
                  cnt_n   = LEN_W'(1);
                  state_n = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (din_valid) begin
               if (cnt_inc_c == len_q) begin
                  done_c     = 1'b1;
                  done_val_c = sum_c;
               end else begin
                  acc_n = sum_c;
                  cnt_n = cnt_inc_c;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Completion clears the running sum so the next valid sample starts a new run
      if (done_c) begin
         acc_out_n   = done_val_c;
         acc_valid_n = 1'b1;
         dump_cnt_n  = dump_cnt + 16'd1;
         acc_n       = '0;
         cnt_n       = '0;
         state_n     = ctrl_reg[1] ? ACCUM : IDLE;
      end

      busy_n = (state_n != IDLE);
   end

   // State and output registers
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q      <= IDLE;
         start_q      <= 1'b1;
         len_q        <= '0;
         cnt_q        <= '0;
         acc_q        <= '0;
         acc_out      <= '0;
         acc_valid    <= 1'b0;
         busy         <= 1'b0;
         dump_cnt     <= '0;
         err_zero_len <= 1'b0;
      end else begin
         state_q      <= state_n;
         start_q      <= ctrl_reg[0];
         len_q        <= len_n;
         cnt_q        <= cnt_n;
         acc_q        <= acc_n;
         acc_out      <= acc_out_n;
         acc_valid    <= acc_valid_n;
         busy         <= busy_n;
         dump_cnt     <= dump_cnt_n;
         err_zero_len <= err_zero_len_n;
      end
   end

endmodule

// File: doc/chan_packet_accum_ctrl.md
CHAN_PACKET_ACCUM_CTRL -- requirements
Module: chan_packet_accum_ctrl

Interface
REQ-001 Parameter IN_W, default 16, signed input sample width.
REQ-002 Parameter ACC_W, default 32, accumulator width; SHALL equal IN_W+16.
REQ-003 user_clk  input  1  single clock; every register SHALL be clocked on its rising edge.
REQ-004 user_rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 ctrl_reg  input  32  software control word from the startAccumulator register: bit0 start, bit1 continuous, [31:16] integration length N, other bits ignored.
REQ-006 din  input  IN_W  signed channel sample.
REQ-007 din_valid  input  1  din qualifier.
REQ-008 sync_in  input  1  frame marker; SHALL be honoured only when din_valid=1.
REQ-009 acc_out  output  ACC_W  signed integrated sum.
REQ-010 acc_valid  output  1  one-cycle strobe qualifying acc_out.
REQ-011 busy  output  1  high in ARM or ACCUM.
REQ-012 dump_cnt  output  16  count of acc_valid strobes.
REQ-013 err_zero_len  output  1  sticky; set by a start with N=0.

Function
REQ-014 FSM states: IDLE, ARM, ACCUM.
REQ-015 start_q SHALL be a register holding the previous ctrl_reg[0]; start edge = ctrl_reg[0] & ~start_q.
REQ-016 IDLE, start edge, N!=0: latch N into len_q, clear acc and cnt, go to ARM.
REQ-017 IDLE, start edge, N=0: set err_zero_len, stay in IDLE.
REQ-018 Start edges in ARM or ACCUM SHALL be ignored; a ctrl_reg change mid-integration SHALL NOT affect len_q.
REQ-019 ARM: din_valid&sync_in SHALL accumulate that sample as sample 1 and go to ACCUM (or complete when len_q=1); sync_in in other states SHALL be ignored.
REQ-020 ACCUM: each din_valid cycle SHALL add sign-extended din to acc and increment cnt; cycles without din_valid SHALL hold both.
REQ-021 Completion: on the cycle the len_q-th valid sample is accepted, next cycle acc_out = sum of those len_q samples, acc_valid=1 for exactly one cycle, dump_cnt+1 (wraps 65535->0).
REQ-022 At completion acc and cnt SHALL clear in the same cycle, so a valid sample on the following cycle is sample 1 of the next integration (no lost samples).
REQ-023 At completion, ctrl_reg[1]=1: go to ACCUM with len_q retained; ctrl_reg[1]=0: go to IDLE.
REQ-024 acc_out SHALL hold its value between strobes.
REQ-025 Arithmetic SHALL be two's-complement, full width; no overflow is possible for N<=65535.
REQ-026 Latency SHALL be exactly 1 cycle from the last accepted sample to acc_valid.

Reset
REQ-027 user_rst=1: state IDLE; acc, cnt, len_q, acc_out, acc_valid, dump_cnt, err_zero_len all cleared; busy=0.
REQ-028 start_q SHALL reset to 1, so a ctrl_reg[0] already high at reset release does not start; a 0->1 transition is required.
REQ-029 Reset asserted mid-integration SHALL abandon the partial sum with no acc_valid strobe.

Verification
REQ-030 N=4, single shot, sync on first sample, din=1,2,3,4 consecutive -> acc_valid 1 cycle after 4th, acc_out=10, dump_cnt=1, state IDLE, busy=0.
REQ-031 N=3, continuous, din=-5 on every cycle -> acc_out=-15 every 3rd cycle, no gaps; clear bit1 -> IDLE after current integration.
REQ-032 N=2, din_valid toggling 1,0,1 with din=7,x,9 -> acc_out=16; invalid cycle not counted.
REQ-033 ctrl_reg=0x00000001 (N=0) -> err_zero_len=1, busy=0, no acc_valid.
REQ-034 ctrl_reg[0] high through reset release -> no start; then 0->1 with N=1, sync with din=0x7FFF -> acc_out=32767.
REQ-035 N=8, reset after 5 samples -> no acc_valid, all outputs 0; sync_in in IDLE/ACCUM ignored.
